// File: rtl/ptw_axi_read_port.sv
// Page-table-walk read port: arbitrates ITLB/DTLB PTE requests onto a single
// outstanding single-beat 64-bit AXI4 read and returns each PTE as a one-cycle pulse.
module ptw_axi_read_port #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  I_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] I_ADDR,
   output logic                  I_DATA_VALID,
   output logic [DATA_WIDTH-1:0] I_DATA,
   output logic                  I_ACCESS_FAULT,
   input  logic                  D_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] D_ADDR,
   output logic                  D_DATA_VALID,
   output logic [DATA_WIDTH-1:0] D_DATA,
   output logic                  D_ACCESS_FAULT,
   output logic                  PROTO_ERR,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_ARADDR,
   output logic [ID_WIDTH-1:0]   M_ARID,
   output logic [7:0]            M_ARLEN,
   output logic [2:0]            M_ARSIZE,
   output logic [1:0]            M_ARBURST,
   output logic [2:0]            M_ARPROT,
   input  logic                  M_RVALID,
   output logic                  M_RREADY,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP,
   input  logic [ID_WIDTH-1:0]   M_RID,
   input  logic                  M_RLAST
);

   localparam logic [ID_WIDTH-1:0] ID_I = '0;
   localparam logic [ID_WIDTH-1:0] ID_D = ID_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

   state_t                r_state;
   logic                  r_i_pend, r_d_pend;
   logic [ADDR_WIDTH-1:0] r_i_addr, r_d_addr;
   logic                  r_last_i;
   logic                  r_arvalid, r_rready;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [ID_WIDTH-1:0]   r_arid;
   logic                  r_i_dv, r_d_dv, r_i_flt, r_d_flt, r_perr;
   logic [DATA_WIDTH-1:0] r_i_data, r_d_data;

   logic                  w_busy, w_i_fly, w_d_fly;
   logic                  w_i_acc, w_d_acc, w_i_req, w_d_req;
   logic                  w_gnt_i, w_gnt_d, w_rerr;
   logic [ADDR_WIDTH-1:0] w_i_sel, w_d_sel;

   // The in-flight port is identified by the registered ARID while the FSM is busy.
   assign w_busy  = (r_state != S_IDLE);
   assign w_i_fly = w_busy && (r_arid == ID_I);
   assign w_d_fly = w_busy && (r_arid == ID_D);
   assign w_i_acc = I_ADDR_VALID && !r_i_pend && !w_i_fly;
   assign w_d_acc = D_ADDR_VALID && !r_d_pend && !w_d_fly;
   assign w_i_req = r_i_pend || w_i_acc;
   assign w_d_req = r_d_pend || w_d_acc;
   assign w_i_sel = r_i_pend ? r_i_addr : I_ADDR;
   assign w_d_sel = r_d_pend ? r_d_addr : D_ADDR;

   // Last-grant bit only moves on contended grants, so an uncontended grant
   // does not steal the other port's turn.
   assign w_gnt_d = !w_busy && w_d_req && (!w_i_req || r_last_i);
   assign w_gnt_i = !w_busy && w_i_req && !w_gnt_d;
   assign w_rerr  = (M_RRESP >= 2'b10) || (M_RID != r_arid) || !M_RLAST;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state   <= S_IDLE;
         r_i_pend  <= 1'b0;
         r_d_pend  <= 1'b0;
         r_i_addr  <= '0;
         r_d_addr  <= '0;
         r_last_i  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_araddr  <= '0;
         r_arid    <= '0;
         r_i_dv    <= 1'b0;
         r_d_dv    <= 1'b0;
         r_i_flt   <= 1'b0;
         r_d_flt   <= 1'b0;
         r_i_data  <= '0;
         r_d_data  <= '0;
         r_perr    <= 1'b0;
      end else begin
         r_i_dv   <= 1'b0;
         r_d_dv   <= 1'b0;
         r_i_flt  <= 1'b0;
         r_d_flt  <= 1'b0;
         r_perr   <= (I_ADDR_VALID && !w_i_acc) || (D_ADDR_VALID && !w_d_acc);
         r_i_pend <= w_i_req && !w_gnt_i;
         r_d_pend <= w_d_req && !w_gnt_d;
         if (w_i_acc) r_i_addr <= I_ADDR;
         if (w_d_acc) r_d_addr <= D_ADDR;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_i || w_gnt_d) begin
                  r_arvalid <= 1'b1;
                  r_araddr  <= w_gnt_d ? w_d_sel : w_i_sel;
                  r_arid    <= w_gnt_d ? ID_D : ID_I;
                  if (w_i_req && w_d_req) r_last_i <= w_gnt_i;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (M_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (M_RVALID) begin
                  r_rready <= 1'b0;
                  if (r_arid == ID_D) begin
                     r_d_dv   <= 1'b1;
                     r_d_data <= M_RDATA;
                     r_d_flt  <= w_rerr;
                  end else begin
                     r_i_dv   <= 1'b1;
                     r_i_data <= M_RDATA;
                     r_i_flt  <= w_rerr;
                  end
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign I_DATA_VALID   = r_i_dv;
   assign I_DATA         = r_i_data;
   assign I_ACCESS_FAULT = r_i_flt;
   assign D_DATA_VALID   = r_d_dv;
   assign D_DATA         = r_d_data;
   assign D_ACCESS_FAULT = r_d_flt;
   assign PROTO_ERR      = r_perr;
   assign M_ARVALID      = r_arvalid;
   assign M_ARADDR       = r_araddr;
   assign M_ARID         = r_arid;
   assign M_RREADY       = r_rready;
   assign M_ARLEN        = 8'd0;
   assign M_ARSIZE       = 3'd3;
   assign M_ARBURST      = 2'd1;
   assign M_ARPROT       = 3'b001;

endmodule

// File: tb/tb_ptw_axi_read_port.sv
// Bench for ptw_axi_read_port: per-port request/transaction model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ptw_axi_read_port;

   logic        clk, rst_n;
   logic        i_av, d_av;
   logic [63:0] i_addr, d_addr;
   logic        arready, rvalid, rlast, rid_flip;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic [0:0]  ar_id_cap, m_rid;

   logic        I_DATA_VALID, I_ACCESS_FAULT, D_DATA_VALID, D_ACCESS_FAULT, PROTO_ERR;
   logic [63:0] I_DATA, D_DATA, M_ARADDR;
   logic        M_ARVALID, M_RREADY;
   logic [0:0]  M_ARID;
   logic [7:0]  M_ARLEN;
   logic [2:0]  M_ARSIZE, M_ARPROT;
   logic [1:0]  M_ARBURST;

   assign m_rid = rid_flip ? ~ar_id_cap : ar_id_cap;

   ptw_axi_read_port dut (
      .CLK(clk), .RSTN(rst_n),
      .I_ADDR_VALID(i_av), .I_ADDR(i_addr), .I_DATA_VALID(I_DATA_VALID), .I_DATA(I_DATA),
      .I_ACCESS_FAULT(I_ACCESS_FAULT),
      .D_ADDR_VALID(d_av), .D_ADDR(d_addr), .D_DATA_VALID(D_DATA_VALID), .D_DATA(D_DATA),
      .D_ACCESS_FAULT(D_ACCESS_FAULT),
      .PROTO_ERR(PROTO_ERR),
      .M_ARVALID(M_ARVALID), .M_ARREADY(arready), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
      .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
      .M_RVALID(rvalid), .M_RREADY(M_RREADY), .M_RDATA(rdata), .M_RRESP(rresp),
      .M_RID(m_rid), .M_RLAST(rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Transaction model: each port is free / pending / in flight; one AXI read at a time.
   localparam int FREE = 0, PEND = 1, FLY = 2;
   int          m_st [2];
   logic [63:0] m_addr [2];
   int          m_ph, m_cur, m_prio;
   logic        e_arv, e_rr, e_perr;
   logic [63:0] e_araddr;
   logic [0:0]  e_arid;
   logic        e_dv [2], e_flt [2];
   logic [63:0] e_data [2];

   task model_reset();
      for (int p = 0; p < 2; p++) begin
         m_st[p] = FREE; m_addr[p] = '0; e_dv[p] = 0; e_flt[p] = 0; e_data[p] = '0;
      end
      m_ph = 0; m_cur = 0; m_prio = 0;
      e_arv = 0; e_rr = 0; e_perr = 0; e_araddr = '0; e_arid = '0;
   endtask

   task model_step();
      logic v [2];
      logic [63:0] a [2];
      int w;
      v[0] = i_av; v[1] = d_av; a[0] = i_addr; a[1] = d_addr;
      e_perr = 0;
      for (int p = 0; p < 2; p++) begin
         e_dv[p] = 0; e_flt[p] = 0;
         if (v[p]) begin
            if (m_st[p] == FREE) begin m_st[p] = PEND; m_addr[p] = a[p]; end
            else e_perr = 1;
         end
      end
      if (m_ph == 0) begin
         if (m_st[0] == PEND || m_st[1] == PEND) begin
            if (m_st[0] == PEND && m_st[1] == PEND) begin w = m_prio; m_prio = 1 - w; end
            else w = (m_st[1] == PEND) ? 1 : 0;
            m_st[w] = FLY; m_cur = w; m_ph = 1;
            e_arv = 1; e_araddr = m_addr[w]; e_arid = 1'(w);
         end
      end else if (m_ph == 1) begin
         if (arready) begin e_arv = 0; e_rr = 1; m_ph = 2; end
      end else begin
         if (rvalid) begin
            e_rr = 0; m_ph = 0; m_st[m_cur] = FREE;
            e_dv[m_cur] = 1; e_data[m_cur] = rdata;
            e_flt[m_cur] = rresp[1] || (int'(m_rid) != m_cur) || !rlast;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      check("ar", {M_ARVALID, M_ARADDR, M_ARID}, {e_arv, e_araddr, e_arid});
      check("rready", M_RREADY, e_rr);
      check("iresp", {I_DATA_VALID, I_ACCESS_FAULT, I_DATA}, {e_dv[0], e_flt[0], e_data[0]});
      check("dresp", {D_DATA_VALID, D_ACCESS_FAULT, D_DATA}, {e_dv[1], e_flt[1], e_data[1]});
      check("perr", PROTO_ERR, e_perr);
      check("axi_const", {M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT}, {8'd0, 3'd3, 2'd1, 3'b001});
      if (rst_n) model_step();
   end

   // Observation monitors for the directed literal checks.
   int i_dv_cnt = 0, d_dv_cnt = 0, perr_cnt = 0;
   logic i_last_flt = 0, d_last_flt = 0;
   logic [0:0] ar_log [$];
   always @(negedge clk) begin
      if (I_DATA_VALID) begin i_dv_cnt <= i_dv_cnt + 1; i_last_flt <= I_ACCESS_FAULT; end
      if (D_DATA_VALID) begin d_dv_cnt <= d_dv_cnt + 1; d_last_flt <= D_ACCESS_FAULT; end
      if (PROTO_ERR) perr_cnt <= perr_cnt + 1;
      if (rst_n && M_ARVALID && arready) begin
         ar_log.push_back(M_ARID);
         ar_id_cap <= M_ARID;
      end
   end

   task tick();
      @(posedge clk); #1;
   endtask

   task pulse(input logic ip, input logic dp, input logic [63:0] ia, input logic [63:0] da);
      i_av = ip; d_av = dp; i_addr = ia; d_addr = da;
      tick();
      i_av = 0; d_av = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int n0, c0, c1;
      rst_n = 0; i_av = 0; d_av = 0; i_addr = '0; d_addr = '0;
      arready = 0; rvalid = 0; rlast = 1; rid_flip = 0; rdata = '0; rresp = '0;
      ar_id_cap = '0;
      repeat (3) tick();
      check("rst_out", {M_ARVALID, M_RREADY, I_DATA_VALID, D_DATA_VALID, PROTO_ERR,
                        I_ACCESS_FAULT, D_ACCESS_FAULT, M_ARID}, 8'd0);
      check("rst_addr", M_ARADDR, 64'd0);
      rst_n = 1;
      repeat (6) tick();

      // ITLB single read, minimum latency
      arready = 1; rvalid = 1; rdata = 64'h0000_0000_2000_00CF; rresp = 0;
      i_av = 1; i_addr = 64'h8000_1008;
      @(negedge clk); check("t1_pre", M_ARVALID, 1'b0);
      @(posedge clk); #1; i_av = 0;
      @(negedge clk); check("t1_ar", {M_ARVALID, M_ARADDR, M_ARID}, {1'b1, 64'h8000_1008, 1'b0});
      @(negedge clk); check("t1_rready", M_RREADY, 1'b1);
      @(negedge clk); check("t1_data", {I_DATA_VALID, I_ACCESS_FAULT, I_DATA},
                            {1'b1, 1'b0, 64'h0000_0000_2000_00CF});
      @(negedge clk); check("t1_hold", {I_DATA_VALID, I_DATA}, {1'b0, 64'h0000_0000_2000_00CF});
      tick();

      // Simultaneous requests: I then D, repeat gives D then I
      rdata = 64'h0000_0000_AAAA_0001;
      n0 = ar_log.size();
      pulse(1, 1, 64'h1000, 64'h2000);
      repeat (10) tick();
      rdata = 64'h0000_0000_AAAA_0002;
      pulse(1, 1, 64'h1008, 64'h2008);
      repeat (10) tick();
      check("arb_cnt", ar_log.size(), n0 + 4);
      if (ar_log.size() >= n0 + 4) begin
         check("arb_0", ar_log[n0],   1'b0);
         check("arb_1", ar_log[n0+1], 1'b1);
         check("arb_2", ar_log[n0+2], 1'b1);
         check("arb_3", ar_log[n0+3], 1'b0);
      end

      // Backpressure: ARREADY low 5 cycles, RVALID delayed 7 cycles
      arready = 0; rvalid = 0; rdata = 64'hBEEF_0000_0000_0001;
      c0 = d_dv_cnt;
      pulse(0, 1, '0, 64'h3008);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_ar", {M_ARVALID, M_ARADDR, M_ARID}, {1'b1, 64'h3008, 1'b1});
      end
      @(posedge clk); #1; arready = 1;
      tick(); arready = 0;
      repeat (7) tick();
      check("bp_rready", M_RREADY, 1'b1);
      rvalid = 1;
      tick(); rvalid = 0;
      repeat (3) tick();
      check("bp_one_pulse", d_dv_cnt, c0 + 1);

      // Error responses
      arready = 1; rvalid = 1; rresp = 2'b10; rdata = 64'h0000_0000_0000_0E01;
      pulse(1, 0, 64'h4000, '0);
      repeat (5) tick();
      check("err_rresp", {i_last_flt, I_DATA}, {1'b1, 64'h0000_0000_0000_0E01});
      rresp = 2'b00; rid_flip = 1;
      pulse(0, 1, '0, 64'h5000);
      repeat (5) tick();
      check("err_rid", d_last_flt, 1'b1);
      rid_flip = 0;

      // Second pulse while in flight is dropped with PROTO_ERR
      arready = 0;
      c0 = i_dv_cnt; c1 = perr_cnt;
      pulse(1, 0, 64'h6000, '0);
      pulse(1, 0, 64'h7000, '0);
      arready = 1;
      repeat (6) tick();
      check("proto_err", perr_cnt, c1 + 1);
      check("proto_one_resp", i_dv_cnt, c0 + 1);

      // Request in the delivery cycle is accepted
      c0 = i_dv_cnt; c1 = perr_cnt;
      pulse(1, 0, 64'h6100, '0);
      tick(); tick();
      pulse(1, 0, 64'h6200, '0);
      repeat (6) tick();
      check("deliv_accept", {i_dv_cnt, perr_cnt}, {c0 + 2, c1});

      // Reset mid-transaction
      rvalid = 0;
      pulse(1, 0, 64'h8000, '0);
      for (int k = 0; k < 10 && !M_RREADY; k++) @(negedge clk);
      check("rst_wait_data", M_RREADY, 1'b1);
      c0 = i_dv_cnt;
      @(posedge clk); #1; rst_n = 0; #1;
      check("rst_async", {M_RREADY, M_ARVALID}, 2'b00);
      rvalid = 1;
      repeat (2) tick();
      rst_n = 1;
      repeat (4) tick();
      check("rst_no_data", {i_dv_cnt, M_RREADY}, {c0, 1'b0});
      rdata = 64'h0000_0000_0000_9001;
      pulse(1, 0, 64'h9000, '0);
      repeat (5) tick();
      check("rst_fresh", {i_dv_cnt, I_DATA}, {c0 + 1, 64'h0000_0000_0000_9001});

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ptw_axi_read_port.md
# ptw_axi_read_port

Responder side of the TLB page-table-walk memory interface. Accepts single-cycle PTE read request pulses from the instruction TLB and the data TLB. Arbitrates between them and performs one single-beat 64-bit AXI4 read at a time. Returns each PTE to its requester as a one-cycle data-valid pulse. Sits between the TLBs' `ADDR_TO_AXIM*` / `DATA_FROM_AXIM*` ports and the system AXI interconnect.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, request and AXI address width.
- `DATA_WIDTH`, 64, PTE and AXI data width (must be 64).
- `ID_WIDTH`, 1, ARID/RID width; ID 0 = ITLB, ID 1 = DTLB.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RSTN`  in  1  reset: asynchronous, active-low.
- `I_ADDR_VALID`  in  1  ITLB request pulse.
- `I_ADDR`  in  ADDR_WIDTH  ITLB PTE address, 8-byte aligned.
- `I_DATA_VALID`  out  1  ITLB response pulse.
- `I_DATA`  out  DATA_WIDTH  ITLB PTE.
- `I_ACCESS_FAULT`  out  1  ITLB response carried RRESP error.
- `D_ADDR_VALID`, `D_ADDR`, `D_DATA_VALID`, `D_DATA`, `D_ACCESS_FAULT`: same as the `I_*` ports, for the DTLB.
- `PROTO_ERR`  out  1  pulse: request dropped because that port already had a request outstanding.
- `M_ARVALID`  out  1  AXI read address valid.
- `M_ARREADY`  in  1  AXI read address ready.
- `M_ARADDR`  out  ADDR_WIDTH  AXI read address.
- `M_ARID`  out  ID_WIDTH  AXI read ID.
- `M_ARLEN`  out  8  AXI burst length, constant 0.
- `M_ARSIZE`  out  3  AXI beat size, constant 3.
- `M_ARBURST`  out  2  AXI burst type, constant INCR (1).
- `M_ARPROT`  out  3  AXI protection, constant 3'b001.
- `M_RVALID`  in  1  AXI read data valid.
- `M_RREADY`  out  1  AXI read data ready.
- `M_RDATA`  in  DATA_WIDTH  AXI read data.
- `M_RRESP`  in  2  AXI read response.
- `M_RID`  in  ID_WIDTH  AXI read ID.
- `M_RLAST`  in  1  AXI last beat.

## Operation
- **Request capture.** Each port has a pending flag and an address register.
  - `x_ADDR_VALID` high sets the port's pending flag and captures `x_ADDR`.
  - The port must be neither pending nor in flight. Otherwise the pulse is dropped, the existing request is unaffected, and `PROTO_ERR` pulses next cycle.
- **Same-cycle request and response.** A pulse arriving in the cycle the port's response is delivered (`x_DATA_VALID` high) is accepted.
- **FSM states and transitions:**
  - `IDLE`: if any pending flag is set, choose a winner, load `M_ARADDR`/`M_ARID`, assert `M_ARVALID`, clear the winner's pending flag, mark it in flight, and go to `ADDR`.
  - `ADDR`: hold `M_ARVALID` and the AR fields stable until `M_ARREADY`. Then drop `M_ARVALID`, raise `M_RREADY`, and go to `DATA`.
  - `DATA`: on `M_RVALID`, drop `M_RREADY`, register the response to the in-flight port, and go to `IDLE`.
- **Arbitration.**
  - Round-robin using a last-grant bit; after reset, ITLB has priority.
  - With both ports pending, grants alternate.
  - With one port pending, it always wins.
- **Response.**
  - `x_DATA` <= `M_RDATA`; `x_DATA_VALID` pulses for exactly 1 cycle.
  - `x_ACCESS_FAULT` = `M_RRESP[1]`, valid only with `x_DATA_VALID`.
  - `x_DATA` holds its value until that port's next response.
  - `M_RID` must equal `M_ARID` and `M_RLAST` must be 1. A mismatch on either is treated as an error response: access fault set, data still delivered.
- **One outstanding transaction at a time.** A new request from the other port is latched while busy and granted on the first cycle back in `IDLE`.
- **Reset.**
  - All outputs 0: `M_ARVALID`, `M_RREADY`, `M_ARADDR`, `M_ARID`, all `x_DATA*`, `x_ACCESS_FAULT`, `PROTO_ERR`. The AXI constant outputs always drive their constant values.
  - Pending and in-flight flags clear; last-grant selects ITLB.
  - FSM returns to `IDLE`.
  - Reset mid-transaction abandons the transfer. No response is delivered, and an R beat arriving after reset release is never accepted because `M_RREADY` is 0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Request pulse at cycle T in `IDLE`, other port idle: `M_ARVALID` high at T+1.
- AR handshake at cycle A: `M_RREADY` high at A+1.
- R handshake at cycle R: `x_DATA_VALID` at R+1; FSM is in `IDLE` at R+1 and may issue the next AR at R+2.
- Minimum latency, `ARREADY` and `RVALID` tied high: request at T, data at T+3. Back-to-back sustained throughput: one PTE per 3 cycles.
- `M_ARVALID`, once high, never drops before `M_ARREADY` (AXI rule).

## Test plan
- **ITLB single read:** ITLB pulse at cycle 10, `I_ADDR`=0x8000_1008, `ARREADY`=`RVALID`=1, `RDATA`=0x0000_0000_2000_00CF, `RRESP`=0 -> AR at cycle 11 with `ARADDR`=0x8000_1008, `ARID`=0; `I_DATA_VALID` pulses at cycle 13 with that PTE; `I_ACCESS_FAULT`=0.
- **Simultaneous requests:** ITLB and DTLB pulse in the same cycle -> ITLB granted first (`ARID` 0), then DTLB (`ARID` 1). A repeat of the simultaneous pulse then grants DTLB first.
- **Backpressure:** `ARREADY` low 5 cycles, then `RVALID` delayed 7 cycles -> `ARVALID`/`ARADDR` stable throughout; exactly one `D_DATA_VALID` pulse, one cycle after the R handshake.
- **Error responses:** `RRESP`=2'b10 -> data delivered with `x_ACCESS_FAULT`=1. `RID` mismatch -> same behaviour. A second pulse on a port already in flight -> `PROTO_ERR` pulse, only one response delivered.
- **Reset mid-transaction:** `RSTN` low while in `DATA` -> `M_RREADY` and `M_ARVALID` go to 0 asynchronously. After release, no data pulse occurs, and a fresh request completes normally.
